pulse_generator: RTL

Produces clean, filter-safe pulse trains on a single output from a one-shot command handshake. It is the transmitting end of the deglitch path: every high and low phase it emits is at least FILTER_SIZE+1 cycles long, so a downstream deglitch filter with the same FILTER_SIZE passes each pulse unchanged. It sits between control logic and any pin or net that is later deglitched.

---
 rtl/pulse_gen_defs.sv | 13 +
 rtl/phase_counter.sv | 34 +++
 rtl/pulse_generator.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pulse_gen_defs.sv
// Shared definitions for the pulse generator and its matching deglitch filter.
package pulse_gen_defs;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HIGH = 2'b01;
  localparam logic [1:0] LOW  = 2'b10;

  // Shortest phase a filter of this size passes unchanged.
  function automatic int unsigned min_phase(input int unsigned filter_size);
    return filter_size + 1;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter; terminal flags the last cycle of a phase (count == 1).
module phase_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             terminal_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pulse_generator.sv
// Emits R pulses of H high / L low cycles per command, each phase at least MIN_PH long.
module pulse_generator
  import pulse_gen_defs::*;
#(
  parameter int unsigned FILTER_SIZE = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MIN_PH = min_phase(FILTER_SIZE);
  localparam logic [CNT_W-1:0] MinPhW = CNT_W'(MIN_PH);

  function automatic logic [CNT_W-1:0] at_least(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lo);
    return (v < lo) ? lo : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, l_q, l_d, rpt_q, rpt_d, rpt_eff;
  logic             pulse_out_q, pulse_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             cnt_load, cnt_en, cnt_term;
  logic [CNT_W-1:0] cnt_load_val;

  assign start_ready = (state_q == IDLE);
  assign accept      = start_valid & start_ready;
  // Abort collapses the remaining repeats to the one in flight.
  assign rpt_eff     = abort ? CNT_W'(1) : rpt_q;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    l_d          = l_q;
    rpt_d        = rpt_q;
    cnt_load     = 1'b0;
    cnt_load_val = h_q;
    cnt_en       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          h_d          = at_least(high_len, MinPhW);
          l_d          = at_least(low_len, MinPhW);
          rpt_d        = at_least(repeat_cnt, CNT_W'(1));
          cnt_load     = 1'b1;
          cnt_load_val = h_d;
          state_d      = HIGH;
        end
      end
      HIGH: begin
        rpt_d = rpt_eff;
        if (cnt_term) begin
          cnt_load     = 1'b1;
          cnt_load_val = l_q;
          state_d      = LOW;
        end else begin
          cnt_en = 1'b1;
        end
      end
      LOW: begin
        if (cnt_term) begin
          rpt_d = rpt_eff - CNT_W'(1);
          if (rpt_d != '0) begin
            cnt_load     = 1'b1;
            cnt_load_val = h_q;
            state_d      = HIGH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          rpt_d  = rpt_eff;
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    pulse_out_d = (state_d == HIGH);
    busy_d      = (state_d == HIGH) || (state_d == LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_q         <= '0;
      l_q         <= '0;
      rpt_q       <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      l_q         <= l_d;
      rpt_q       <= rpt_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (cnt_en),
    .terminal_o(cnt_term)
  );

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
